// File: rtl/opl_bus_pkg.sv
// opl_bus_pkg: shared types and constants for the OPL bus master
package opl_bus_pkg;
   typedef enum logic [2:0] {IDLE, ADDR_STB, ADDR_WAIT, DATA_STB, DATA_WAIT, RD_STB} opl_state_t;
   typedef struct packed {
      logic [7:0] reg_no;
      logic [7:0] data;
   } opl_wr_t;
   localparam logic OPL_PORT_ADDR = 1'b0;
   localparam logic OPL_PORT_DATA = 1'b1;
   function automatic int max3(int a, int b, int c);
      return a > b ? (a > c ? a : c) : (b > c ? b : c);
   endfunction
endpackage

// File: rtl/opl_bus_master_if.sv
// opl_bus_master_if: host write/status handshake plus OPL chip-side pins
interface opl_bus_master_if;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_reg, wr_data;
   logic       stat_req, stat_valid;
   logic [7:0] stat_data;
   logic       busy;
   logic       opl_addr;
   logic [7:0] opl_din;
   logic       opl_we, opl_rd;
   logic [7:0] opl_dout;
   logic       opl_irq_n, irq;
   modport master (
      input  wr_valid, wr_reg, wr_data, stat_req, opl_dout, opl_irq_n,
      output wr_ready, stat_valid, stat_data, busy, opl_addr, opl_din, opl_we, opl_rd, irq
   );
   modport slave (
      output wr_valid, wr_reg, wr_data, stat_req, opl_dout, opl_irq_n,
      input  wr_ready, stat_valid, stat_data, busy, opl_addr, opl_din, opl_we, opl_rd, irq
   );
endinterface

// File: rtl/opl_bus_fifo.sv
// opl_bus_fifo: write-request queue, power-of-two depth, async active-high reset
module opl_bus_fifo import opl_bus_pkg::*; #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  opl_wr_t                  din,
   output opl_wr_t                  dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
   opl_wr_t mem [DEPTH];
   ptr_t wp_q, wp_d, rp_q, rp_d;
   cnt_t cnt_q, cnt_d;
   logic do_push, do_pop;
   assign full    = cnt_q == FULL_CNT;
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign dout    = mem[rp_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   always_comb begin
      wp_d  = wp_q + ptr_t'(do_push);
      rp_d  = rp_q + ptr_t'(do_pop);
      cnt_d = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp_q] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
endmodule

// File: rtl/opl_bus_master.sv
// opl_bus_master: queues OPL register writes and replays them as timed address/data strobes, plus status reads
// Define OPL_ADDR_CACHE_EN to skip the address phase when the register number repeats.
module opl_bus_master import opl_bus_pkg::*; #(
   parameter int FIFO_DEPTH = 8,
   parameter int STB_LEN    = 4,
   parameter int ADDR_GAP   = 12,
   parameter int DATA_GAP   = 84
) (
   input logic               clk,
   input logic               rst,
   opl_bus_master_if.master  bus
);
   // the address wait always lasts at least one cycle so the two strobes never merge
   localparam int AGAP = ADDR_GAP < 1 ? 1 : ADDR_GAP;
   localparam int CW   = $clog2(max3(STB_LEN, AGAP, DATA_GAP) + 1);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t STB_RL = cnt_t'(STB_LEN - 1);
   localparam cnt_t AG_RL  = cnt_t'(AGAP - 1);
   localparam cnt_t DG_RL  = cnt_t'(DATA_GAP > 0 ? DATA_GAP - 1 : 0);
   opl_state_t state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   opl_wr_t    cur_q, cur_d, head;
   logic       we_q, we_d, rd_q, rd_d, addr_q, addr_d;
   logic [7:0] din_q, din_d, sdata_q, sdata_d;
   logic       sval_q, pend_q, pend_d;
   logic [1:0] sync_q, sync_d;
   logic       full, empty, pop, rd_issue, hit, done, enter, rd_last;
   logic [$clog2(FIFO_DEPTH):0] fcnt;
   opl_bus_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(bus.wr_valid), .pop(pop),
      .din({bus.wr_reg, bus.wr_data}), .dout(head),
      .full(full), .empty(empty), .count(fcnt)
   );
`ifdef OPL_ADDR_CACHE_EN
   logic [7:0] creg_q, creg_d;
   logic       cvld_q, cvld_d;
   assign hit = cvld_q && head.reg_no == creg_q;
   // a status read leaves the chip's address latch unknown to us
   always_comb begin
      creg_d = pop ? head.reg_no : creg_q;
      cvld_d = rd_issue ? 1'b0 : pop ? 1'b1 : cvld_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         creg_q <= '0;
         cvld_q <= 1'b0;
      end else begin
         creg_q <= creg_d;
         cvld_q <= cvld_d;
      end
`else
   assign hit = 1'b0;
`endif
   assign done    = cnt_q == '0;
   assign enter   = state_d != state_q;
   assign rd_last = state_q == RD_STB && done;
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      rd_issue = 1'b0;
      case (state_q)
         IDLE:
            if (pend_q) begin
               state_d  = RD_STB;
               rd_issue = 1'b1;
            end else if (!empty) begin
               pop = 1'b1;
               if (hit) state_d = DATA_STB;
               else     state_d = ADDR_STB;
            end
         ADDR_STB:  if (done) state_d = ADDR_WAIT;
         ADDR_WAIT: if (done) state_d = DATA_STB;
         DATA_STB, RD_STB:
            if (done) begin
               if (DATA_GAP > 0) state_d = DATA_WAIT;
               else              state_d = IDLE;
            end
         DATA_WAIT: if (done) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end
   always_comb begin
      cnt_d   = !enter ? cnt_q - 1'b1 : state_d == ADDR_WAIT ? AG_RL : state_d == DATA_WAIT ? DG_RL : STB_RL;
      cur_d   = pop ? head : cur_q;
      we_d    = state_d == ADDR_STB || state_d == DATA_STB;
      rd_d    = state_d == RD_STB;
      addr_d  = !enter ? addr_q : state_d == DATA_STB ? OPL_PORT_DATA :
                (state_d == ADDR_STB || state_d == RD_STB) ? OPL_PORT_ADDR : addr_q;
      din_d   = !enter ? din_q : state_d == ADDR_STB ? cur_d.reg_no : state_d == DATA_STB ? cur_d.data : din_q;
      sdata_d = rd_last ? bus.opl_dout : sdata_q;
      pend_d  = bus.stat_req || (pend_q && !rd_issue);
      sync_d  = {sync_q[0], ~bus.opl_irq_n};
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cur_q   <= '0;
         we_q    <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= 1'b0;
         din_q   <= '0;
         sdata_q <= '0;
         sval_q  <= 1'b0;
         pend_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         sdata_q <= sdata_d;
         sval_q  <= rd_last;
         pend_q  <= pend_d;
         sync_q  <= sync_d;
      end
   assign bus.wr_ready   = !full;
   assign bus.busy       = fcnt != '0 || state_q != IDLE || pend_q;
   assign bus.opl_we     = we_q;
   assign bus.opl_rd     = rd_q;
   assign bus.opl_addr   = addr_q;
   assign bus.opl_din    = din_q;
   assign bus.stat_data  = sdata_q;
   assign bus.stat_valid = sval_q;
   assign bus.irq        = sync_q[1];
endmodule

// File: tb/tb_opl_bus_master.sv
// tb_opl_bus_master: random and directed checks of opl_bus_master against a strobe-sequence model
module tb_opl_bus_master;
   localparam int FD = 8, SL = 4, AG = 12, DG = 84;
`ifdef OPL_ADDR_CACHE_EN
   localparam int EXP_A = 2;
`else
   localparam int EXP_A = 3;
`endif
   typedef struct { logic port; logic [7:0] din; int len; int gap; bit stable; } strb_t;
   typedef struct { bit d; logic [7:0] v; } ev_t;
   logic clk = 1'b0, rst = 1'b1;
   int n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   opl_bus_master_if bus();
   opl_bus_master #(.FIFO_DEPTH(FD), .STB_LEN(SL), .ADDR_GAP(AG), .DATA_GAP(DG)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   // chip-side monitor: turns pin activity into a list of strobes
   strb_t obs_q[$];
   strb_t cur;
   int low = 1000, rd_n = 0, rd_len = 0, rd_gap = 0, sv_n = 0;
   bit in_we = 0, in_rd = 0, rd_port_ok = 0, sv_at_end = 0;
   logic [7:0] sv_data = '0;
   always @(negedge clk) begin
      if (rst) begin
         in_we = 0;
         in_rd = 0;
         low = 1000;
      end else begin
         if (bus.opl_we) begin
            if (!in_we) begin
               cur = '{bus.opl_addr, bus.opl_din, 1, low, 1'b1};
               low = 0;
               in_we = 1;
            end else begin
               cur.len++;
               if (bus.opl_addr != cur.port || bus.opl_din != cur.din) cur.stable = 0;
            end
         end else if (in_we) begin
            obs_q.push_back(cur);
            in_we = 0;
         end
         if (bus.opl_rd) begin
            if (!in_rd) begin
               rd_n++;
               rd_gap = low;
               low = 0;
               rd_len = 0;
               rd_port_ok = 1;
               in_rd = 1;
            end
            rd_len++;
            if (bus.opl_addr) rd_port_ok = 0;
         end else if (in_rd) begin
            in_rd = 0;
            sv_at_end = bus.stat_valid;
         end
         if (!bus.opl_we && !bus.opl_rd) low++;
         if (bus.stat_valid) begin
            sv_n++;
            sv_data = bus.stat_data;
         end
      end
   end
   // reference model: each accepted write becomes an address strobe (unless cached) and a data strobe
   ev_t exp_q[$];
   int obs_rd = 0;
   bit cvld = 0;
   logic [7:0] creg = '0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic model_wr(logic [7:0] r, logic [7:0] d);
      bit skip;
      skip = cvld && creg == r;
`ifndef OPL_ADDR_CACHE_EN
      skip = 0;
`endif
      if (!skip) exp_q.push_back('{1'b0, r});
      exp_q.push_back('{1'b1, d});
      cvld = 1;
      creg = r;
   endtask
   task automatic do_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
      cvld = 0;
      exp_q.delete();
      obs_rd = obs_q.size();
      tick();
   endtask
   task automatic push(logic [7:0] r, logic [7:0] d);
      int n = 0;
      bus.wr_valid = 1;
      bus.wr_reg = r;
      bus.wr_data = d;
      while (!bus.wr_ready && n < 2000) begin
         tick();
         n++;
      end
      chk("push_ready", bus.wr_ready, 1);
      if (bus.wr_ready) model_wr(r, d);
      tick();
      bus.wr_valid = 0;
   endtask
   task automatic wait_idle(int bound);
      int n = 0;
      while (bus.busy && n < bound) begin
         tick();
         n++;
      end
      chk("idle_timeout", bus.busy, 0);
   endtask
   task automatic wait_we(logic port);
      int n = 0;
      while (!(bus.opl_we && bus.opl_addr == port) && n < 500) begin
         tick();
         n++;
      end
      chk("wait_we", bus.opl_we, 1);
   endtask
   task automatic cmp_strobes();
      chk("n_strobes", obs_q.size() - obs_rd, exp_q.size());
      for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
         strb_t o;
         o = obs_q[obs_rd + i];
         chk("port", o.port, exp_q[i].d);
         chk("din", o.din, exp_q[i].v);
         chk("stb_len", o.len, SL);
         chk("stable", o.stable, 1);
         if (exp_q[i].d && i > 0 && !exp_q[i-1].d) chk("addr_gap", o.gap, AG);
         else chk("data_gap_min", o.gap >= DG, 1);
      end
      obs_rd = obs_q.size();
      exp_q.delete();
   endtask
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int i, n, acc, low_at, rd0, sv0, na;
      logic h [24];
      bus.wr_valid = 0;
      bus.wr_reg = '0;
      bus.wr_data = '0;
      bus.stat_req = 0;
      bus.opl_dout = 8'h33;
      bus.opl_irq_n = 1;
      do_reset();
      chk("rst_ready", bus.wr_ready, 1);
      chk("rst_we", bus.opl_we, 0);
      chk("rst_rd", bus.opl_rd, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_addr", bus.opl_addr, 0);
      chk("rst_din", bus.opl_din, 0);
      chk("rst_sval", bus.stat_valid, 0);
      chk("rst_sdata", bus.stat_data, 0);
      chk("rst_irq", bus.irq, 0);
      // single write: latency, strobe shape and busy duration
      push(8'h20, 8'h01);
      chk("lat_we0", bus.opl_we, 0);
      chk("lat_busy", bus.busy, 1);
      tick();
      chk("lat_we1", bus.opl_we, 1);
      chk("lat_port", bus.opl_addr, 0);
      chk("lat_din", bus.opl_din, 8'h20);
      i = 1;
      while (bus.busy && i < 1000) begin
         tick();
         i++;
      end
      chk("busy_drop", i, 1 + 2*SL + AG + DG);
      cmp_strobes();
      // burst of 10 with wr_valid held
      do_reset();
      acc = 0;
      low_at = -1;
      n = 0;
      bus.wr_valid = 1;
      while (acc < 10 && n < 3000) begin
         bus.wr_reg = 8'(8'h30 + acc);
         bus.wr_data = 8'(acc * 7 + 1);
         if (bus.wr_ready) begin
            model_wr(bus.wr_reg, bus.wr_data);
            acc++;
         end else if (low_at < 0) low_at = acc;
         tick();
         n++;
      end
      bus.wr_valid = 0;
      chk("burst_acc", acc, 10);
      chk("ready_low_at", low_at, FD + 1);
      wait_idle(10000);
      cmp_strobes();
      // status read requested during the data strobe
      do_reset();
      rd0 = rd_n;
      sv0 = sv_n;
      push(8'h40, 8'h55);
      wait_we(1);
      bus.stat_req = 1;
      tick();
      bus.stat_req = 0;
      n = 0;
      while (!bus.opl_rd && n < 500) begin
         tick();
         n++;
      end
      chk("rd_seen", bus.opl_rd, 1);
      bus.opl_dout = 8'h5A;
      repeat (SL - 1) tick();
      bus.opl_dout = 8'hE0;
      tick();
      bus.opl_dout = 8'h77;
      wait_idle(1000);
      cvld = 0;
      chk("rd_count", rd_n - rd0, 1);
      chk("sv_count", sv_n - sv0, 1);
      chk("stat_data", sv_data, 8'hE0);
      chk("rd_gap", rd_gap, DG + 1);
      chk("rd_len", rd_len, SL);
      chk("rd_port", rd_port_ok, 1);
      chk("sv_timing", sv_at_end, 1);
      cmp_strobes();
      // two requests while busy merge into one read
      do_reset();
      rd0 = rd_n;
      sv0 = sv_n;
      push(8'h50, 8'h66);
      wait_we(0);
      bus.stat_req = 1;
      tick();
      bus.stat_req = 0;
      tick();
      tick();
      bus.stat_req = 1;
      tick();
      bus.stat_req = 0;
      wait_idle(1000);
      chk("merge_rd", rd_n - rd0, 1);
      chk("merge_sv", sv_n - sv0, 1);
      cmp_strobes();
      // asynchronous reset during the address wait with entries queued
      do_reset();
      push(8'h60, 8'h01);
      push(8'h61, 8'h02);
      push(8'h62, 8'h03);
      wait_we(0);
      n = 0;
      while (bus.opl_we && n < 50) begin
         tick();
         n++;
      end
      chk("in_addr_wait", bus.opl_we, 0);
      rst = 1;
      #1;
      chk("arst_we", bus.opl_we, 0);
      chk("arst_ready", bus.wr_ready, 1);
      chk("arst_busy", bus.busy, 0);
      do_reset();
      repeat (300) tick();
      chk("post_rst_strobes", obs_q.size() - obs_rd, 0);
      chk("post_rst_busy", bus.busy, 0);
      // address cache sequence
      do_reset();
      push(8'hA0, 8'h11);
      push(8'hA0, 8'h22);
      push(8'hB0, 8'h33);
      wait_idle(2000);
      na = 0;
      for (int k = obs_rd; k < obs_q.size(); k++) if (!obs_q[k].port) na++;
      chk("addr_strobes", na, EXP_A);
      cmp_strobes();
      // random writes
      do_reset();
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         push(8'(8'hA0 + $urandom_range(0, 3)), 8'($urandom));
      end
      wait_idle(20000);
      cmp_strobes();
      // irq synchroniser
      for (int k = 0; k < 24; k++) begin
         bus.opl_irq_n = 1'($urandom_range(0, 1));
         h[k] = ~bus.opl_irq_n;
         tick();
         if (k >= 1) chk("irq", bus.irq, h[k-1]);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
